pmix_phase_detector: RTL and testbench
======================================

// Module: pmix_phase_detector
// PURPOSE
//  Measures the clk-cycle delay between a rising edge of clk_in and the next
//  rising edge of pmix_clk, and returns the recovered 8-bit phase code.
//  Delay D maps to code = D-1, so D=1 gives code 0 and D=256 gives code 255.
//  Sits beside the phase mixer as its inverse: bench/BIST closed-loop code check.
//  All inputs are synchronous to clk; no synchronizers.
// PARAMETERS
//  CODE_W     8             width of the code; MAX_DELAY = 2**CODE_W
//  MAX_DELAY  2**CODE_W     largest legal delay in clk cycles (localparam)
// PORTS
//  clk          in   1       sampling clock
//  rst_n        in   1       async active-low reset
//  start        in   1       1-cycle pulse; starts a measurement when idle
//  clk_in       in   1       reference clock as seen by the mixer
//  pmix_clk     in   1       mixer output
//  pmix_clk_90  in   1       mixer quadrature output; used only with the macro
//  busy         out  1       high from accepted start until the result handshake
//  code_out     out  CODE_W  recovered code; held stable while code_valid
//  code_valid   out  1       result valid
//  code_ready   in   1       consumer accepts the result
//  timeout      out  1       qualifies the result: no pmix edge within MAX_DELAY
//  quad_err     out  1       qualifies the result: quadrature mismatch (macro)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, cnt 0, edge registers 0.
//  Edge detect: x_rise = x & ~x_d, where x_d is the registered previous sample.
//  IDLE
//   start=1 -> ARM, busy=1. start in any other state is ignored.
//  ARM
//   Waits for ref_rise; no timeout. On ref_rise: cnt<=1, go COUNT.
//   A mix_rise in the same cycle as ref_rise is ignored.
//  COUNT (cnt is 9 bits)
//   Increment cnt every cycle.
//   mix_rise: code_out<=cnt-1, timeout<=0, go RESULT.
//    Without the macro the first valid result is at ref_rise+D+1.
//   mix_rise takes priority when cnt==MAX_DELAY (code 255 is legal).
//   No mix_rise and cnt==MAX_DELAY: code_out<=all-ones, timeout<=1, go RESULT.
//   Further ref_rise edges while in COUNT are ignored (delay can exceed period).
//  RESULT
//   code_valid=1, with code_out, timeout and quad_err held stable.
//   code_valid & code_ready: clear code_valid and busy, go IDLE.
//   start in the same cycle is not accepted.
//  Reset mid-operation: immediate return to reset values; no partial result.
// CONFIGURATION
//  PMIX_DET_QUAD_CHECK_EN defined:
//   In COUNT, record d90 = cnt at the first pmix_clk_90 rise.
//   mix_rise goes to CHK90 (1 cycle) instead of RESULT, so a D+1 edge is seen.
//   Then go RESULT with quad_err=1 unless d90==D+1, or d90==1 when code==255
//   (the mixer wraps). No 90 edge seen also sets quad_err=1.
//   Latency is +1 cycle.
//  Undefined: pmix_clk_90 is unused and quad_err is tied 0.
// STRUCTURE
//  pmix_pkg: CODE_W, MAX_DELAY, typedef enum pdet_state_e
//   {IDLE, ARM, COUNT, CHK90, RESULT}.
//  Sub-module pmix_edge_det: registered rising-edge detector,
//   instantiated per monitored clock (2, or 3 with the macro).
// TESTING
//  1 Mixer code=0, start -> code_valid with code_out=0, timeout=0,
//    busy low after the ready handshake.
//  2 Mixer code=100 -> code_out=100.
//    With the macro: quad_err=0, d90 = 102 clk after ref.
//  3 Mixer code=255 -> code_out=255, timeout=0.
//    With the macro: quad_err=0 (wrap case d90=1).
//  4 pmix_clk held 0 -> after 256 COUNT cycles: code_valid=1, timeout=1,
//    code_out=8'hFF.
//  5 code_ready held 0 for 10 cycles -> code_out and code_valid stable.
//    start pulses ignored; busy=1 throughout.
//  6 rst_n asserted mid-COUNT -> busy, code_valid, code_out = 0 at once.
//    A fresh start then measures the correct code.

Source files
------------

// File: rtl/pmix_pkg.sv
// rtl/pmix_pkg.sv - shared constants and state type for the mixer phase detector
package pmix_pkg;

  localparam int CODE_W    = 8;
  localparam int MAX_DELAY = 2 ** CODE_W;
  localparam int CNT_W     = CODE_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    COUNT,
    CHK90,
    RESULT
  } pdet_state_e;

endpackage

// File: rtl/pmix_edge_det.sv
// rtl/pmix_edge_det.sv - rising-edge detector on a clk-synchronous level
module pmix_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  output logic rise
);

  logic x_d;

  // previous sample of the monitored level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_d <= 1'b0;
    end else begin
      x_d <= x;
    end
  end

  assign rise = x & ~x_d;

endmodule

// File: rtl/pmix_phase_detector.sv
// rtl/pmix_phase_detector.sv - recovers the mixer phase code from the clk_in to pmix_clk delay (optional PMIX_DET_QUAD_CHECK_EN)
module pmix_phase_detector
  import pmix_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clk_in,
  input  logic              pmix_clk,
  input  logic              pmix_clk_90,
  output logic              busy,
  output logic [CODE_W-1:0] code_out,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              timeout,
  output logic              quad_err
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DELAY);

  pdet_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic             ref_rise;
  logic             mix_rise;

  pmix_edge_det u_ref_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (clk_in),
    .rise  (ref_rise)
  );

  pmix_edge_det u_mix_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (pmix_clk),
    .rise  (mix_rise)
  );

`ifdef PMIX_DET_QUAD_CHECK_EN
  logic             q_rise;
  logic [CNT_W-1:0] d90;
  logic [CNT_W-1:0] d90_fin;
  logic [CNT_W:0]   exp90;
  logic             quad_ok;

  pmix_edge_det u_q_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (pmix_clk_90),
    .rise  (q_rise)
  );

  // the 90 edge may land in the CHK90 cycle itself (delay D+1), so fold it in here
  always_comb begin
    d90_fin = d90;
    if (d90 == '0 && q_rise) begin
      d90_fin = cnt;
    end
    exp90   = (CNT_W + 1)'(code_out) + (CNT_W + 1)'(2);
    quad_ok = ({1'b0, d90_fin} == exp90) ||
              ((code_out == '1) && (d90_fin == CNT_ONE));
  end
`else
  logic unused_quad;
  assign unused_quad = pmix_clk_90;
  assign quad_err    = 1'b0;
`endif

  // measurement sequencer with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      code_out   <= '0;
      code_valid <= 1'b0;
      timeout    <= 1'b0;
`ifdef PMIX_DET_QUAD_CHECK_EN
      quad_err   <= 1'b0;
      d90        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= ARM;
          end
        end
        ARM: begin
          // a pmix edge coinciding with the reference edge is not a measurement
          if (ref_rise) begin
            cnt   <= CNT_ONE;
            state <= COUNT;
`ifdef PMIX_DET_QUAD_CHECK_EN
            d90   <= '0;
`endif
          end
        end
        COUNT: begin
          cnt <= cnt + CNT_ONE;
`ifdef PMIX_DET_QUAD_CHECK_EN
          if (q_rise && d90 == '0) begin
            d90 <= cnt;
          end
`endif
          // a pmix edge at the last count still wins, so code 255 is reachable
          if (mix_rise) begin
            code_out <= cnt[CODE_W-1:0] - {{(CODE_W-1){1'b0}}, 1'b1};
            timeout  <= 1'b0;
`ifdef PMIX_DET_QUAD_CHECK_EN
            state    <= CHK90;
`else
            code_valid <= 1'b1;
            state      <= RESULT;
`endif
          end else if (cnt == CNT_MAX) begin
            code_out   <= '1;
            timeout    <= 1'b1;
            code_valid <= 1'b1;
            state      <= RESULT;
`ifdef PMIX_DET_QUAD_CHECK_EN
            quad_err   <= 1'b0;
`endif
          end
        end
        CHK90: begin
`ifdef PMIX_DET_QUAD_CHECK_EN
          quad_err   <= ~quad_ok;
          code_valid <= 1'b1;
          state      <= RESULT;
`else
          state <= IDLE;
`endif
        end
        RESULT: begin
          if (code_ready) begin
            code_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmix_phase_detector.sv
// tb/tb_pmix_phase_detector.sv - directed self-checking bench for pmix_phase_detector
module tb_pmix_phase_detector;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       clk_in;
  logic       pmix_clk;
  logic       pmix_clk_90;
  logic       busy;
  logic [7:0] code_out;
  logic       code_valid;
  logic       code_ready;
  logic       timeout;
  logic       quad_err;

  int checks;
  int failures;

`ifdef PMIX_DET_QUAD_CHECK_EN
  localparam int LAT_EXTRA = 1;
`else
  localparam int LAT_EXTRA = 0;
`endif

  pmix_phase_detector dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .clk_in      (clk_in),
    .pmix_clk    (pmix_clk),
    .pmix_clk_90 (pmix_clk_90),
    .busy        (busy),
    .code_out    (code_out),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .timeout     (timeout),
    .quad_err    (quad_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // start pulse, reference edge, pmix edge dmix cycles later, 90 edge d90 cycles later (0 = none)
  task automatic run_capture(input int dmix, input int d90, output int lat, output logic busy_seen);
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    busy_seen = busy;
    clk_in    = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (code_valid && lat < 0) lat = k;
      if (k == 3) clk_in = 1'b0;
      if (dmix >= 50 && k == 40) clk_in = 1'b1;
      if (dmix >= 50 && k == 43) clk_in = 1'b0;
      if (k == dmix) pmix_clk = 1'b1;
      if (k == dmix + 3) pmix_clk = 1'b0;
      if (k == d90) pmix_clk_90 = 1'b1;
      if (k == d90 + 3) pmix_clk_90 = 1'b0;
      if (lat > 0 && k >= lat + 3) break;
    end
    clk_in      = 1'b0;
    pmix_clk    = 1'b0;
    pmix_clk_90 = 1'b0;
  endtask

  task automatic do_handshake();
    @(negedge clk);
    code_ready = 1'b1;
    @(negedge clk);
    code_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    start       = 1'b0;
    clk_in      = 1'b0;
    pmix_clk    = 1'b0;
    pmix_clk_90 = 1'b0;
    code_ready  = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (code_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", code_valid); end
    checks++; if (code_out !== 8'h00) begin failures++; $display("FAIL reset_code got=%h exp=00", code_out); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    checks++; if (quad_err !== 1'b0) begin failures++; $display("FAIL reset_quad got=%b exp=0", quad_err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_code(input int code, input string name);
    int   lat;
    logic bs;
    int   d90;
    d90 = (code == 255) ? 1 : code + 2;
    run_capture(code + 1, d90, lat, bs);
    checks++; if (bs !== 1'b1) begin failures++; $display("FAIL %s busy_armed got=%b exp=1", name, bs); end
    checks++; if (lat != code + 2 + LAT_EXTRA) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, code + 2 + LAT_EXTRA); end
    checks++; if (code_out !== 8'(code)) begin failures++; $display("FAIL %s code_out got=%0d exp=%0d", name, code_out, code); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL %s timeout got=%b exp=0", name, timeout); end
    checks++; if (quad_err !== 1'b0) begin failures++; $display("FAIL %s quad_err got=%b exp=0", name, quad_err); end
    do_handshake();
    checks++; if (code_valid !== 1'b0) begin failures++; $display("FAIL %s valid_after_hs got=%b exp=0", name, code_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_after_hs got=%b exp=0", name, busy); end
  endtask

  task automatic test_timeout();
    int   lat;
    logic bs;
    run_capture(0, 0, lat, bs);
    checks++; if (lat != 257) begin failures++; $display("FAIL timeout latency got=%0d exp=257", lat); end
    checks++; if (code_valid !== 1'b1) begin failures++; $display("FAIL timeout valid got=%b exp=1", code_valid); end
    checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL timeout flag got=%b exp=1", timeout); end
    checks++; if (code_out !== 8'hFF) begin failures++; $display("FAIL timeout code got=%h exp=ff", code_out); end
    do_handshake();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout busy_after_hs got=%b exp=0", busy); end
  endtask

  task automatic test_hold_ready();
    int   lat;
    logic bs;
    run_capture(61, 62, lat, bs);
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      @(negedge clk);
      checks++; if (code_valid !== 1'b1) begin failures++; $display("FAIL hold valid[%0d] got=%b exp=1", i, code_valid); end
      checks++; if (code_out !== 8'd60) begin failures++; $display("FAIL hold code[%0d] got=%0d exp=60", i, code_out); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hold busy[%0d] got=%b exp=1", i, busy); end
    end
    start = 1'b0;
    do_handshake();
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold idle_after got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    clk_in = 1'b1;
    repeat (3) @(negedge clk);
    clk_in = 1'b0;
    repeat (17) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst busy got=%b exp=0", busy); end
    checks++; if (code_valid !== 1'b0) begin failures++; $display("FAIL midrst valid got=%b exp=0", code_valid); end
    checks++; if (code_out !== 8'h00) begin failures++; $display("FAIL midrst code got=%h exp=00", code_out); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_code(37, "after_rst");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_code(0, "code0");
    test_code(100, "code100");
    test_code(255, "code255");
    test_timeout();
    test_hold_ready();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
